// File: rtl/cgra_noc_iface.sv
// Tile network interface on the router Local port: TX packetizes PE results into
// header flits through a small FIFO; RX filters by address into a 2-entry skid buffer.
module cgra_noc_iface #(
    parameter int DATA_WIDTH    = 32,
    parameter int COORD_WIDTH   = 4,
    parameter int PAYLOAD_WIDTH = 16,
    parameter int X_COORD       = 0,
    parameter int Y_COORD       = 0,
    parameter int TX_DEPTH      = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PAYLOAD_WIDTH-1:0]     tx_payload,
    input  logic [COORD_WIDTH-1:0]       tx_dst_x,
    input  logic [COORD_WIDTH-1:0]       tx_dst_y,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic [DATA_WIDTH-1:0]        inj_data,
    output logic                         inj_valid,
    input  logic                         inj_ready,
    input  logic [DATA_WIDTH-1:0]        ej_data,
    input  logic                         ej_valid,
    output logic                         ej_ready,
    output logic [PAYLOAD_WIDTH-1:0]     rx_payload,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic [$clog2(TX_DEPTH):0]    tx_level,
    output logic [CNT_WIDTH-1:0]         tx_count,
    output logic [CNT_WIDTH-1:0]         rx_count,
    output logic [CNT_WIDTH-1:0]         misroute_count,
    output logic                         err_misroute
);
    localparam int AW     = $clog2(TX_DEPTH);
    localparam int LW     = AW + 1;
    localparam int HDR_W  = 2 * COORD_WIDTH;
    localparam int RSVD_W = DATA_WIDTH - HDR_W - PAYLOAD_WIDTH;
    localparam logic [COORD_WIDTH-1:0] MY_X = COORD_WIDTH'(X_COORD);
    localparam logic [COORD_WIDTH-1:0] MY_Y = COORD_WIDTH'(Y_COORD);
    localparam logic [LW-1:0] TX_FULL = LW'(TX_DEPTH);
    // Address match compares only DX/DY; RSVD and payload bits are masked off.
    localparam logic [DATA_WIDTH-1:0] ADDR_MASK  = {{HDR_W{1'b1}}, {(DATA_WIDTH-HDR_W){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ADDR_MATCH = {MY_X, MY_Y, {(DATA_WIDTH-HDR_W){1'b0}}};

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
        if (en && (v != {CNT_WIDTH{1'b1}})) begin
            return v + CNT_WIDTH'(1);
        end else begin
            return v;
        end
    endfunction

    logic [DATA_WIDTH-1:0]    tx_mem_r [TX_DEPTH];
    logic [AW-1:0]            tx_wr_ptr_r, tx_rd_ptr_r;
    logic [LW-1:0]            tx_level_r, tx_level_nxt_s;
    logic                     tx_ready_r, inj_valid_r;
    logic [CNT_WIDTH-1:0]     tx_count_r;
    logic                     tx_push_s, tx_pop_s;
    logic [DATA_WIDTH-1:0]    tx_flit_s;

    logic [PAYLOAD_WIDTH-1:0] rx_mem_r [2];
    logic                     rx_wr_ptr_r, rx_rd_ptr_r;
    logic [1:0]               rx_level_r, rx_level_nxt_s;
    logic                     ej_ready_r, rx_valid_r, err_misroute_r;
    logic [CNT_WIDTH-1:0]     rx_count_r, misroute_count_r;
    logic                     ej_hs_s, addr_ok_s, rx_enq_s, rx_drop_s, rx_deq_s;

    assign tx_push_s = tx_valid & tx_ready_r;
    assign tx_pop_s  = inj_valid_r & inj_ready;
    assign tx_flit_s = {tx_dst_x, tx_dst_y, {RSVD_W{1'b0}}, tx_payload};

    assign ej_hs_s   = ej_valid & ej_ready_r;
    assign addr_ok_s = ((ej_data & ADDR_MASK) == ADDR_MATCH);
    assign rx_enq_s  = ej_hs_s & addr_ok_s;
    assign rx_drop_s = ej_hs_s & ~addr_ok_s;
    assign rx_deq_s  = rx_valid_r & rx_ready;

    // Next occupancy of both queues from this cycle's push/pop pair.
    always_comb begin
        tx_level_nxt_s = tx_level_r;
        rx_level_nxt_s = rx_level_r;
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_level_nxt_s = tx_level_r + LW'(1);
            2'b01:   tx_level_nxt_s = tx_level_r - LW'(1);
            default: tx_level_nxt_s = tx_level_r;
        endcase
        case ({rx_enq_s, rx_deq_s})
            2'b10:   rx_level_nxt_s = rx_level_r + 2'd1;
            2'b01:   rx_level_nxt_s = rx_level_r - 2'd1;
            default: rx_level_nxt_s = rx_level_r;
        endcase
    end

    // TX FIFO; ready/valid flags are registered copies of the next occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TX_DEPTH; i++) tx_mem_r[i] <= {DATA_WIDTH{1'b0}};
            tx_wr_ptr_r <= {AW{1'b0}};
            tx_rd_ptr_r <= {AW{1'b0}};
            tx_level_r  <= {LW{1'b0}};
            tx_ready_r  <= 1'b0;
            inj_valid_r <= 1'b0;
            tx_count_r  <= {CNT_WIDTH{1'b0}};
        end else begin
            if (tx_push_s) begin
                tx_mem_r[tx_wr_ptr_r] <= tx_flit_s;
                tx_wr_ptr_r           <= tx_wr_ptr_r + AW'(1);
            end
            if (tx_pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + AW'(1);
            end
            tx_level_r  <= tx_level_nxt_s;
            tx_ready_r  <= (tx_level_nxt_s != TX_FULL);
            inj_valid_r <= (tx_level_nxt_s != {LW{1'b0}});
            tx_count_r  <= sat_inc(tx_count_r, tx_pop_s);
        end
    end

    // RX skid buffer with address filter and drop reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_mem_r[0]      <= {PAYLOAD_WIDTH{1'b0}};
            rx_mem_r[1]      <= {PAYLOAD_WIDTH{1'b0}};
            rx_wr_ptr_r      <= 1'b0;
            rx_rd_ptr_r      <= 1'b0;
            rx_level_r       <= 2'd0;
            ej_ready_r       <= 1'b0;
            rx_valid_r       <= 1'b0;
            err_misroute_r   <= 1'b0;
            rx_count_r       <= {CNT_WIDTH{1'b0}};
            misroute_count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (rx_enq_s) begin
                rx_mem_r[rx_wr_ptr_r] <= ej_data[PAYLOAD_WIDTH-1:0];
                rx_wr_ptr_r           <= ~rx_wr_ptr_r;
            end
            if (rx_deq_s) begin
                rx_rd_ptr_r <= ~rx_rd_ptr_r;
            end
            rx_level_r       <= rx_level_nxt_s;
            ej_ready_r       <= (rx_level_nxt_s != 2'd2);
            rx_valid_r       <= (rx_level_nxt_s != 2'd0);
            err_misroute_r   <= rx_drop_s;
            rx_count_r       <= sat_inc(rx_count_r, rx_deq_s);
            misroute_count_r <= sat_inc(misroute_count_r, rx_drop_s);
        end
    end

    assign tx_ready       = tx_ready_r;
    assign inj_valid      = inj_valid_r;
    assign inj_data       = tx_mem_r[tx_rd_ptr_r];
    assign tx_level       = tx_level_r;
    assign tx_count       = tx_count_r;
    assign ej_ready       = ej_ready_r;
    assign rx_valid       = rx_valid_r;
    assign rx_payload     = rx_mem_r[rx_rd_ptr_r];
    assign rx_count       = rx_count_r;
    assign misroute_count = misroute_count_r;
    assign err_misroute   = err_misroute_r;
endmodule

// File: tb/tb_cgra_noc_iface.sv
// Bench for cgra_noc_iface: directed scenarios plus random traffic against a queue model.
module tb_cgra_noc_iface;
    localparam int CW    = 6;
    localparam int DEPTH = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0, rst = 1'b1;
    logic [15:0] tx_payload = 16'h0000;
    logic [3:0]  tx_dst_x = 4'h0, tx_dst_y = 4'h0;
    logic        tx_valid = 1'b0, inj_ready = 1'b0, ej_valid = 1'b0, rx_ready = 1'b0;
    logic [31:0] ej_data = 32'h0;
    logic        tx_ready, inj_valid, ej_ready, rx_valid, err_misroute;
    logic [31:0] inj_data;
    logic [15:0] rx_payload;
    logic [2:0]  tx_level;
    logic [CW-1:0] tx_count, rx_count, misroute_count;

    cgra_noc_iface #(.X_COORD(1), .Y_COORD(1), .TX_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .tx_payload(tx_payload), .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .inj_data(inj_data), .inj_valid(inj_valid),
        .inj_ready(inj_ready), .ej_data(ej_data), .ej_valid(ej_valid), .ej_ready(ej_ready),
        .rx_payload(rx_payload), .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_level(tx_level),
        .tx_count(tx_count), .rx_count(rx_count), .misroute_count(misroute_count),
        .err_misroute(err_misroute));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    logic [31:0] m_txq[$];
    logic [15:0] m_rxq[$];
    int m_txc, m_rxc, m_misc;
    bit m_err, m_armed, last_push, last_ejhs;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_txq.delete(); m_rxq.delete();
        m_txc = 0; m_rxc = 0; m_misc = 0; m_err = 0; m_armed = 0;
    endtask

    task automatic check_reset_outputs();
        check_val("rst_tx_ready", tx_ready, 0);   check_val("rst_inj_valid", inj_valid, 0);
        check_val("rst_inj_data", inj_data, 0);   check_val("rst_ej_ready", ej_ready, 0);
        check_val("rst_rx_valid", rx_valid, 0);   check_val("rst_rx_payload", rx_payload, 0);
        check_val("rst_tx_level", tx_level, 0);   check_val("rst_tx_count", tx_count, 0);
        check_val("rst_rx_count", rx_count, 0);   check_val("rst_mis_count", misroute_count, 0);
        check_val("rst_err", err_misroute, 0);
    endtask

    task automatic check_all();
        check_val("tx_ready", tx_ready, (m_armed && m_txq.size() < DEPTH) ? 1 : 0);
        check_val("inj_valid", inj_valid, (m_txq.size() > 0) ? 1 : 0);
        if (m_txq.size() > 0) check_val("inj_data", inj_data, m_txq[0]);
        check_val("tx_level", tx_level, m_txq.size());
        check_val("ej_ready", ej_ready, (m_armed && m_rxq.size() < 2) ? 1 : 0);
        check_val("rx_valid", rx_valid, (m_rxq.size() > 0) ? 1 : 0);
        if (m_rxq.size() > 0) check_val("rx_payload", rx_payload, m_rxq[0]);
        check_val("tx_count", tx_count, m_txc);
        check_val("rx_count", rx_count, m_rxc);
        check_val("misroute_count", misroute_count, m_misc);
        check_val("err_misroute", err_misroute, m_err);
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare at next negedge.
    task automatic step(input logic tv, input logic [15:0] tp, input logic [3:0] tx, input logic [3:0] ty,
                        input logic ir, input logic ev, input logic [31:0] ed, input logic rr);
        bit push, pop, ejhs, match, deq;
        tx_valid = tv; tx_payload = tp; tx_dst_x = tx; tx_dst_y = ty;
        inj_ready = ir; ej_valid = ev; ej_data = ed; rx_ready = rr;
        push  = tv && m_armed && m_txq.size() < DEPTH;
        pop   = m_txq.size() > 0 && ir;
        ejhs  = ev && m_armed && m_rxq.size() < 2;
        match = (ed[31:28] == 4'd1) && (ed[27:24] == 4'd1);
        deq   = m_rxq.size() > 0 && rr;
        @(posedge clk);
        if (pop) begin void'(m_txq.pop_front()); m_txc = sat(m_txc); end
        if (push) m_txq.push_back({tx, ty, 8'h00, tp});
        if (deq) begin void'(m_rxq.pop_front()); m_rxc = sat(m_rxc); end
        if (ejhs && match) m_rxq.push_back(ed[15:0]);
        m_err = ejhs && !match;
        if (m_err) m_misc = sat(m_misc);
        m_armed = 1; last_push = push; last_ejhs = ejhs;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic ir, input logic rr);
        step(1'b0, 16'h0, 4'h0, 4'h0, ir, 1'b0, 32'h0, rr);
    endtask

    function automatic logic [31:0] rand_flit();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 99) < 70) r[31:24] = 8'h11;
        else if (r[31:24] == 8'h11) r[31:24] = 8'h12;
        return r;
    endfunction

    initial begin
        logic pv, evh;
        logic [15:0] pp;
        logic [3:0] px, py;
        logic [31:0] edh;
        int k;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        check_all();
        idle(1'b0, 1'b0);

        // Single packet, header format and injection latency.
        step(1'b1, 16'hBEEF, 4'd2, 4'd3, 1'b1, 1'b0, 32'h0, 1'b0);
        check_val("t1_inj_data", inj_data, 32'h2300BEEF);
        check_val("t1_inj_valid", inj_valid, 1);
        idle(1'b1, 1'b0);
        check_val("t1_tx_count", tx_count, 1);

        // Fill the TX FIFO under back-pressure, then drain in order.
        for (int i = 0; i < 4; i++) step(1'b1, 16'h1000 + 16'(i), 4'(i), 4'(i), 1'b0, 1'b0, 32'h0, 1'b0);
        check_val("t2_level_full", tx_level, 4);
        check_val("t2_ready_full", tx_ready, 0);
        step(1'b1, 16'h1004, 4'd4, 4'd4, 1'b0, 1'b0, 32'h0, 1'b0);
        check_val("t2_no_push_full", last_push, 0);
        step(1'b1, 16'h1004, 4'd4, 4'd4, 1'b1, 1'b0, 32'h0, 1'b0);
        check_val("t2_no_push_on_pop", last_push, 0);
        step(1'b1, 16'h1004, 4'd4, 4'd4, 1'b1, 1'b0, 32'h0, 1'b0);
        check_val("t2_push5", last_push, 1);
        repeat (5) idle(1'b1, 1'b0);
        check_val("t2_tx_count", tx_count, 6);

        // Address filtering.
        step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b1, 32'h11005A5A, 1'b0);
        check_val("t3_rx_valid", rx_valid, 1);
        check_val("t3_rx_payload", rx_payload, 16'h5A5A);
        idle(1'b0, 1'b1);
        check_val("t3_rx_count", rx_count, 1);
        step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b1, 32'h21000001, 1'b1);
        check_val("t3_err_pulse", err_misroute, 1);
        check_val("t3_mis_count", misroute_count, 1);
        idle(1'b0, 1'b1);
        check_val("t3_err_clear", err_misroute, 0);

        // RX back-pressure: buffer holds two, then delivers all in order.
        k = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b1, {16'h11AB, 16'h0100 + 16'(k)}, 1'b0);
            if (last_ejhs) k++;
        end
        check_val("t4_ej_ready_low", ej_ready, 0);
        check_val("t4_accepted", k, 2);
        for (int i = 0; i < 10 && k < 4; i++) begin
            step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b1, {16'h11AB, 16'h0100 + 16'(k)}, 1'b1);
            if (last_ejhs) k++;
        end
        repeat (3) idle(1'b0, 1'b1);
        check_val("t4_rx_count", rx_count, 5);

        // Reset with entries held in both directions.
        for (int i = 0; i < 3; i++) step(1'b1, 16'h7700 + 16'(i), 4'd5, 4'd6, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b1, 32'h1100C0D0 + 32'(i), 1'b0);
        check_val("t5_tx_held", tx_level, 3);
        tx_valid = 1'b0; ej_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all();
        repeat (3) idle(1'b1, 1'b1);

        // Random traffic long enough to saturate the counters.
        pv = 1'b0; evh = 1'b0; pp = 16'h0; px = 4'h0; py = 4'h0; edh = 32'h0;
        for (int i = 0; i < 900; i++) begin
            if (!pv && $urandom_range(0, 99) < 60) begin
                pv = 1'b1; pp = 16'($urandom); px = 4'($urandom_range(0, 3)); py = 4'($urandom_range(0, 3));
            end
            if (!evh && $urandom_range(0, 99) < 55) begin
                evh = 1'b1; edh = rand_flit();
            end else if (evh && $urandom_range(0, 99) < 25) begin
                edh = rand_flit();
            end
            step(pv, pp, px, py, $urandom_range(0, 99) < 70, evh, edh, $urandom_range(0, 99) < 70);
            if (last_push) pv = 1'b0;
            if (last_ejhs) evh = 1'b0;
        end
        check_val("t6_tx_sat", tx_count, CMAX);
        check_val("t6_rx_sat", rx_count, CMAX);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
